// File: rtl/unidad_control_multiciclo_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, ALU operations,
// datapath select codes and FSM state codes.
package unidad_control_multiciclo_pkg;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [2:0] F3_WORD = 3'b010;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JALR   = 2'b10;

   localparam logic [1:0] WB_ALUOUT = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;
   localparam logic [1:0] WB_PC     = 2'b10;
   localparam logic [1:0] WB_IMM    = 2'b11;

   localparam logic [1:0] A_RS1   = 2'b00;
   localparam logic [1:0] A_PC    = 2'b01;
   localparam logic [1:0] A_OLDPC = 2'b10;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_IMM  = 2'b01;
   localparam logic [1:0] B_FOUR = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_EXEC_I   = 4'd3,
      ST_ALU_WB   = 4'd4,
      ST_MEM_ADDR = 4'd5,
      ST_MEM_RD   = 4'd6,
      ST_MEM_WB   = 4'd7,
      ST_MEM_WR   = 4'd8,
      ST_BRANCH   = 4'd9,
      ST_JAL      = 4'd10,
      ST_JALR     = 4'd11,
      ST_UPPER    = 4'd12,
      ST_HALT     = 4'd13
   } state_e;

endpackage

// File: rtl/unidad_control_multiciclo_alu_op_decoder.sv
// Maps Funct3/Funct7_5 to an ALU operation; Funct7_5 only selects SUB on
// register-register ops, while it selects SRA/SRAI on both instruction forms.
module alu_op_decoder
   import unidad_control_multiciclo_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       funct7_5_i,
   input  logic       is_rtype_i,
   output alu_op_e    alu_op_o
);

   always_comb begin
      alu_op_o = ALU_ADD;
      case (funct3_i)
         3'b000: alu_op_o = (is_rtype_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
         3'b001: alu_op_o = ALU_SLL;
         3'b010: alu_op_o = ALU_SLT;
         3'b011: alu_op_o = ALU_SLTU;
         3'b100: alu_op_o = ALU_XOR;
         3'b101: alu_op_o = funct7_5_i ? ALU_SRA : ALU_SRL;
         3'b110: alu_op_o = ALU_OR;
         3'b111: alu_op_o = ALU_AND;
         default: alu_op_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle control FSM for the RV32I core: sequences the shared datapath and
// the single-port memory, one state per cycle, outputs decoded from the state.
//
//  state     | meaning
//  FETCH     | read IR from mem[PC], PC <= PC+4, OldPC <= PC
//  DECODE    | ALUOut <= OldPC+imm (branch/jump/AUIPC target), dispatch on opcode
//  EXEC_R    | rs1 op rs2
//  EXEC_I    | rs1 op imm
//  ALU_WB    | rd <= ALUOut
//  MEM_ADDR  | ALUOut <= rs1+imm, only word accesses accepted
//  MEM_RD    | memory addressed by ALUOut
//  MEM_WB    | rd <= memory data
//  MEM_WR    | memory write strobe for one cycle
//  BRANCH    | compare rs1/rs2, PC <= ALUOut when taken
//  JAL       | rd <= PC, PC <= ALUOut
//  JALR      | rd <= PC, PC <= (rs1+imm) & ~1
//  UPPER     | rd <= imm (LUI) or ALUOut (AUIPC)
//  HALT      | stopped until Reset
module unidad_control_multiciclo
   import unidad_control_multiciclo_pkg::*;
#(
   parameter int STATE_W  = 4,
   parameter int ALU_OP_W = 4
)(
   input  logic                Clk,
   input  logic                Reset,
   input  logic [6:0]          Opcode,
   input  logic [2:0]          Funct3,
   input  logic                Funct7_5,
   input  logic                Zero,
   input  logic                Lt,
   input  logic                Ltu,
   output logic                Pc_We,
   output logic [1:0]          Pc_Src,
   output logic                Ir_We,
   output logic                Addr_Sel,
   output logic                We,
   output logic                Reg_We,
   output logic [1:0]          Wb_Sel,
   output logic [1:0]          Alu_A_Sel,
   output logic [1:0]          Alu_B_Sel,
   output logic [ALU_OP_W-1:0] Alu_Op,
   output logic                Halted,
   output logic                Illegal,
   output logic [STATE_W-1:0]  State_Dbg
);

   state_e  state_q, state_d;
   logic    illegal_q, illegal_d;
   alu_op_e dec_op;
   alu_op_e alu_op;
   logic    taken;

   alu_op_decoder u_alu_op_decoder (
      .funct3_i   (Funct3),
      .funct7_5_i (Funct7_5),
      .is_rtype_i (state_q == ST_EXEC_R),
      .alu_op_o   (dec_op)
   );

   always_comb begin
      taken = 1'b0;
      case (Funct3)
         3'b000: taken = Zero;
         3'b001: taken = ~Zero;
         3'b100: taken = Lt;
         3'b101: taken = ~Lt;
         3'b110: taken = Ltu;
         3'b111: taken = ~Ltu;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            case (Opcode)
               OPC_OP:               state_d = ST_EXEC_R;
               OPC_OP_IMM:           state_d = ST_EXEC_I;
               OPC_LOAD, OPC_STORE:  state_d = ST_MEM_ADDR;
               OPC_BRANCH:           state_d = ST_BRANCH;
               OPC_JAL:              state_d = ST_JAL;
               OPC_JALR:             state_d = ST_JALR;
               OPC_LUI, OPC_AUIPC:   state_d = ST_UPPER;
               OPC_MISC_MEM:         state_d = ST_FETCH;
               OPC_SYSTEM:           state_d = ST_HALT;
               default: begin
                  state_d   = ST_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
         ST_MEM_ADDR: begin
            if (Funct3 != F3_WORD) begin
               state_d   = ST_HALT;
               illegal_d = 1'b1;
            end else if (Opcode == OPC_LOAD) begin
               state_d = ST_MEM_RD;
            end else begin
               state_d = ST_MEM_WR;
            end
         end
         ST_MEM_RD: state_d = ST_MEM_WB;
         ST_BRANCH: begin
            if (Funct3 == 3'b010 || Funct3 == 3'b011) begin
               state_d   = ST_HALT;
               illegal_d = 1'b1;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= ST_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Reset masks every output so an aborted instruction leaves no partial write.
   always_comb begin
      Pc_We     = 1'b0;
      Pc_Src    = PC_SRC_ALU;
      Ir_We     = 1'b0;
      Addr_Sel  = 1'b0;
      We        = 1'b0;
      Reg_We    = 1'b0;
      Wb_Sel    = WB_ALUOUT;
      Alu_A_Sel = A_RS1;
      Alu_B_Sel = B_RS2;
      alu_op    = ALU_ADD;
      Halted    = 1'b0;
      if (!Reset) begin
         case (state_q)
            ST_FETCH: begin
               Ir_We     = 1'b1;
               Alu_A_Sel = A_PC;
               Alu_B_Sel = B_FOUR;
               Pc_We     = 1'b1;
            end
            ST_DECODE: begin
               Alu_A_Sel = A_OLDPC;
               Alu_B_Sel = B_IMM;
            end
            ST_EXEC_R: alu_op = dec_op;
            ST_EXEC_I: begin
               Alu_B_Sel = B_IMM;
               alu_op    = dec_op;
            end
            ST_ALU_WB:   Reg_We = 1'b1;
            ST_MEM_ADDR: Alu_B_Sel = B_IMM;
            ST_MEM_RD:   Addr_Sel = 1'b1;
            ST_MEM_WB: begin
               Addr_Sel = 1'b1;
               Reg_We   = 1'b1;
               Wb_Sel   = WB_MEM;
            end
            ST_MEM_WR: begin
               Addr_Sel = 1'b1;
               We       = 1'b1;
            end
            ST_BRANCH: begin
               alu_op = ALU_SUB;
               if (taken) begin
                  Pc_We  = 1'b1;
                  Pc_Src = PC_SRC_ALUOUT;
               end
            end
            ST_JAL: begin
               Reg_We = 1'b1;
               Wb_Sel = WB_PC;
               Pc_We  = 1'b1;
               Pc_Src = PC_SRC_ALUOUT;
            end
            ST_JALR: begin
               Alu_B_Sel = B_IMM;
               Reg_We    = 1'b1;
               Wb_Sel    = WB_PC;
               Pc_We     = 1'b1;
               Pc_Src    = PC_SRC_JALR;
            end
            ST_UPPER: begin
               Reg_We = 1'b1;
               Wb_Sel = (Opcode == OPC_LUI) ? WB_IMM : WB_ALUOUT;
            end
            ST_HALT: Halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign Alu_Op    = ALU_OP_W'(alu_op);
   assign Illegal   = illegal_q;
   assign State_Dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Random instruction stream against a per-instruction step-list model; expected
// per-cycle outputs are queued by the driver and compared by a monitor at negedge.
module tb_unidad_control_multiciclo;
   import unidad_control_multiciclo_pkg::*;

   logic       Clk, Reset;
   logic [6:0] Opcode;
   logic [2:0] Funct3;
   logic       Funct7_5, Zero, Lt, Ltu;
   logic       Pc_We, Ir_We, Addr_Sel, We, Reg_We, Halted, Illegal;
   logic [1:0] Pc_Src, Wb_Sel, Alu_A_Sel, Alu_B_Sel;
   logic [3:0] Alu_Op, State_Dbg;

   unidad_control_multiciclo dut (
      .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct3(Funct3), .Funct7_5(Funct7_5),
      .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .Pc_We(Pc_We), .Pc_Src(Pc_Src), .Ir_We(Ir_We),
      .Addr_Sel(Addr_Sel), .We(We), .Reg_We(Reg_We), .Wb_Sel(Wb_Sel), .Alu_A_Sel(Alu_A_Sel),
      .Alu_B_Sel(Alu_B_Sel), .Alu_Op(Alu_Op), .Halted(Halted), .Illegal(Illegal),
      .State_Dbg(State_Dbg)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       ir_we, addr_sel, we, reg_we;
      logic [1:0] wb_sel, a_sel, b_sel;
      logic [3:0] alu_op;
      logic       halted, illegal;
   } obs_t;

   typedef enum {C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC,
                 C_FENCE, C_SYS, C_BAD, C_BADMEM, C_BADBR} cls_e;

   obs_t   exp_q[$];
   string  lbl_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;
   bit     force_f  = 0;
   logic [2:0] f_flags = 3'b000;
   state_e pending_st  = ST_FETCH;
   logic   pending_ill = 1'b0;
   bit     need_rst    = 0;

   function automatic cls_e classify(logic [6:0] op, logic [2:0] f3);
      case (op)
         OPC_OP:       return C_R;
         OPC_OP_IMM:   return C_I;
         OPC_LOAD:     return (f3 == 3'b010) ? C_LW : C_BADMEM;
         OPC_STORE:    return (f3 == 3'b010) ? C_SW : C_BADMEM;
         OPC_BRANCH:   return (f3 == 3'b010 || f3 == 3'b011) ? C_BADBR : C_BR;
         OPC_JAL:      return C_JAL;
         OPC_JALR:     return C_JALR;
         OPC_LUI:      return C_LUI;
         OPC_AUIPC:    return C_AUIPC;
         OPC_MISC_MEM: return C_FENCE;
         OPC_SYSTEM:   return C_SYS;
         default:      return C_BAD;
      endcase
   endfunction

   // Cycles spent before FETCH of the next instruction (or before HALT).
   function automatic int seq_len(cls_e c);
      case (c)
         C_R, C_I, C_SW: return 4;
         C_LW: return 5;
         C_FENCE, C_SYS, C_BAD: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic bit halts(cls_e c);
      return c == C_SYS || c == C_BAD || c == C_BADMEM || c == C_BADBR;
   endfunction

   function automatic state_e step_of(cls_e c, int i);
      if (i == 0) return ST_FETCH;
      if (i == 1) return ST_DECODE;
      case (c)
         C_R:    return (i == 2) ? ST_EXEC_R : ST_ALU_WB;
         C_I:    return (i == 2) ? ST_EXEC_I : ST_ALU_WB;
         C_LW:   return (i == 2) ? ST_MEM_ADDR : (i == 3) ? ST_MEM_RD : ST_MEM_WB;
         C_SW:   return (i == 2) ? ST_MEM_ADDR : ST_MEM_WR;
         C_BR, C_BADBR: return ST_BRANCH;
         C_BADMEM: return ST_MEM_ADDR;
         C_JAL:  return ST_JAL;
         C_JALR: return ST_JALR;
         C_LUI, C_AUIPC: return ST_UPPER;
         default: return ST_HALT;
      endcase
   endfunction

   function automatic logic [3:0] alu_of(logic [2:0] f3, logic f75, bit rtype);
      logic [3:0] tbl [8];
      tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      if (f3 == 3'b000 && rtype && f75) return ALU_SUB;
      if (f3 == 3'b101 && f75) return ALU_SRA;
      return tbl[f3];
   endfunction

   function automatic obs_t model(state_e s, logic [6:0] op, logic [2:0] f3, logic f75,
                                  logic z, logic lt, logic ltu, logic ill);
      obs_t o;
      bit tk;
      o = '0;
      o.st = s;
      o.illegal = ill;
      o.alu_op = ALU_ADD;
      tk = (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) || (f3 == 3'b100 && lt) ||
           (f3 == 3'b101 && !lt) || (f3 == 3'b110 && ltu) || (f3 == 3'b111 && !ltu);
      case (s)
         ST_FETCH:    begin o.ir_we = 1; o.a_sel = A_PC; o.b_sel = B_FOUR; o.pc_we = 1; end
         ST_DECODE:   begin o.a_sel = A_OLDPC; o.b_sel = B_IMM; end
         ST_EXEC_R:   o.alu_op = alu_of(f3, f75, 1);
         ST_EXEC_I:   begin o.b_sel = B_IMM; o.alu_op = alu_of(f3, f75, 0); end
         ST_ALU_WB:   o.reg_we = 1;
         ST_MEM_ADDR: o.b_sel = B_IMM;
         ST_MEM_RD:   o.addr_sel = 1;
         ST_MEM_WB:   begin o.addr_sel = 1; o.reg_we = 1; o.wb_sel = WB_MEM; end
         ST_MEM_WR:   begin o.addr_sel = 1; o.we = 1; end
         ST_BRANCH:   begin
            o.alu_op = ALU_SUB;
            if (tk) begin o.pc_we = 1; o.pc_src = PC_SRC_ALUOUT; end
         end
         ST_JAL:  begin o.reg_we = 1; o.wb_sel = WB_PC; o.pc_we = 1; o.pc_src = PC_SRC_ALUOUT; end
         ST_JALR: begin
            o.b_sel = B_IMM; o.reg_we = 1; o.wb_sel = WB_PC; o.pc_we = 1; o.pc_src = PC_SRC_JALR;
         end
         ST_UPPER: begin o.reg_we = 1; o.wb_sel = (op == OPC_LUI) ? WB_IMM : WB_ALUOUT; end
         ST_HALT:  o.halted = 1;
         default: ;
      endcase
      return o;
   endfunction

   task automatic drive_cycle(input state_e s, input bit rst, input logic ill, input string lbl);
      obs_t e;
      Reset = rst;
      if (force_f) {Zero, Lt, Ltu} = f_flags;
      else {Zero, Lt, Ltu} = 3'($urandom);
      if (rst) begin
         e = '0;
         e.st = s;
         e.illegal = ill;
      end else begin
         e = model(s, Opcode, Funct3, Funct7_5, Zero, Lt, Ltu, ill);
      end
      exp_q.push_back(e);
      lbl_q.push_back(lbl);
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++)
         drive_cycle((i == 0) ? pending_st : ST_FETCH, 1, (i == 0) ? pending_ill : 1'b0, "reset");
      pending_st  = ST_FETCH;
      pending_ill = 1'b0;
      need_rst    = 0;
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                            input int abort_at, input int n_halt);
      cls_e c;
      int   n;
      logic ill;
      Opcode = op; Funct3 = f3; Funct7_5 = f75;
      c = classify(op, f3);
      n = seq_len(c);
      for (int i = 0; i < n; i++) begin
         if (i == abort_at && i > 0) begin
            pending_st = step_of(c, i);
            pending_ill = 1'b0;
            need_rst = 1;
            return;
         end
         drive_cycle(step_of(c, i), 0, 1'b0, $sformatf("op%02h f3=%0d c%0d", op, f3, i));
      end
      if (halts(c)) begin
         ill = (c != C_SYS);
         for (int h = 0; h < n_halt; h++)
            drive_cycle(ST_HALT, 0, ill, $sformatf("op%02h halt%0d", op, h));
         pending_st  = ST_HALT;
         pending_ill = ill;
         need_rst    = 1;
      end
   endtask

   initial begin : monitor
      obs_t act, e;
      string l;
      forever begin
         @(negedge Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            act = {State_Dbg, Pc_We, Pc_Src, Ir_We, Addr_Sel, We, Reg_We, Wb_Sel,
                   Alu_A_Sel, Alu_B_Sel, Alu_Op, Halted, Illegal};
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s: got %h (st=%0d) expected %h (st=%0d)", l, act, act.st, e, e.st);
            end
         end
      end
   end

   initial begin : driver
      logic [6:0] legal_ops [11];
      logic [6:0] op;
      logic [2:0] f3;
      int k;
      legal_ops = '{OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL,
                    OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_MISC_MEM, OPC_SYSTEM};
      Reset = 1; Opcode = '0; Funct3 = '0; Funct7_5 = 0; Zero = 0; Lt = 0; Ltu = 0;
      repeat (2) @(posedge Clk);
      #1;
      do_reset(2);

      // Directed cases
      run_instr(OPC_LOAD, 3'b010, 0, 3, 0);           // reset in MEM_RD
      do_reset(3);
      run_instr(OPC_OP, 3'b000, 0, -1, 0);             // ADD
      run_instr(OPC_OP, 3'b000, 1, -1, 0);             // SUB
      run_instr(OPC_OP_IMM, 3'b000, 1, -1, 0);         // ADDI ignores Funct7_5
      run_instr(OPC_OP_IMM, 3'b101, 1, -1, 0);         // SRAI
      run_instr(OPC_LOAD, 3'b010, 0, -1, 0);
      run_instr(OPC_STORE, 3'b010, 0, -1, 0);
      force_f = 1;
      f_flags = 3'b100; run_instr(OPC_BRANCH, 3'b000, 0, -1, 0);  // BEQ taken
      f_flags = 3'b000; run_instr(OPC_BRANCH, 3'b000, 0, -1, 0);  // BEQ not taken
      f_flags = 3'b001; run_instr(OPC_BRANCH, 3'b110, 0, -1, 0);  // BLTU taken
      force_f = 0;
      run_instr(OPC_JALR, 3'b000, 0, -1, 0);
      run_instr(OPC_JAL, 3'b000, 0, -1, 0);
      run_instr(OPC_LUI, 3'b000, 0, -1, 0);
      run_instr(OPC_AUIPC, 3'b000, 0, -1, 0);
      run_instr(OPC_MISC_MEM, 3'b000, 0, -1, 0);
      run_instr(7'h7F, 3'b000, 0, -1, 20);
      do_reset(1);
      run_instr(OPC_SYSTEM, 3'b000, 0, -1, 5);          // ECALL
      do_reset(2);
      run_instr(OPC_LOAD, 3'b001, 0, -1, 3);            // LH unsupported
      do_reset(1);
      run_instr(OPC_BRANCH, 3'b011, 0, -1, 3);
      do_reset(1);

      // Random stream
      for (int t = 0; t < 200; t++) begin
         k = $urandom_range(0, 11);
         op = (k == 11) ? 7'($urandom) : legal_ops[k];
         f3 = 3'($urandom);
         if ((op == OPC_LOAD || op == OPC_STORE) && ($urandom_range(0, 3) != 0)) f3 = 3'b010;
         run_instr(op, f3, 1'($urandom),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : -1,
                   $urandom_range(1, 6));
         if (need_rst) do_reset($urandom_range(1, 3));
      end

      @(posedge Clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
